alu_console: RTL and testbench

ALU_CONSOLE -- requirements
Module: alu_console

---
 rtl/alu_console_pkg.sv | 28 ++
 rtl/alu_console_hex_seg_decoder.sv | 11 +
 rtl/alu_console.sv | 207 ++++++++++++++++++++
 tb/tb_alu_console.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_console_pkg.sv
// Shared types and constants for the ALU console: opcodes, FSM states, hex glyphs.
package alu_console_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Active-low gfedcba glyphs, index = nibble value.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/alu_console_hex_seg_decoder.sv
// One 7-segment digit: nibble in, active-low segment pattern out.
module hex_seg_decoder
    import alu_console_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPH[nib];

endmodule

// File: rtl/alu_console.sv
// Push-button ALU console: debounced keys load A/B and execute; result shown on HEX.
// Build option ALU_CONSOLE_MUL_EN adds the iterative shift-add multiplier for opcode 111.
module alu_console
    import alu_console_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [WIDTH+3:0]         SW,
    input  logic [2:0]               KEY,
    output logic [3:0]               LEDR,
    output logic [7*(WIDTH/2)-1:0]   HEX
);

    localparam int RES_W = 2 * WIDTH;
    localparam int NDIG  = WIDTH / 2;
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] operand;
    assign operand = SW[WIDTH-1:0];

    // Key conditioning: keys idle high, so synchronisers reset to released.
    logic [2:0] sync1, sync2, ev;
    logic [2:0][CNT_W-1:0] cnt;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_deb
        // Counter saturates at DEBOUNCE_CYCLES so a held key fires once.
        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset)
                cnt[k] <= '0;
            else if (sync2[k])
                cnt[k] <= '0;
            else if (cnt[k] != CNT_W'(DEBOUNCE_CYCLES))
                cnt[k] <= cnt[k] + 1'b1;
        end
        assign ev[k] = !sync2[k] && (cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1));
    end

    state_e state, next;
    logic [WIDTH-1:0] a, b;
    logic [RES_W-1:0] result;
    op_e  op_r;
    logic unsig_r, ovf, valid, err, busy;

`ifdef ALU_CONSOLE_MUL_EN
    logic [RES_W-1:0] mcand, acc, acc_nx;
    logic [WIDTH-1:0] mplier, a_nx, b_nx, a_mag, b_mag;
    logic [SH_W-1:0]  mul_cnt;
    logic             neg;

    // Loads in the execute cycle still apply, so the multiplier sees the new operands.
    assign a_nx   = ev[0] ? operand : a;
    assign b_nx   = ev[1] ? operand : b;
    assign a_mag  = (!SW[WIDTH+3] && a_nx[WIDTH-1]) ? -a_nx : a_nx;
    assign b_mag  = (!SW[WIDTH+3] && b_nx[WIDTH-1]) ? -b_nx : b_nx;
    assign acc_nx = acc + (mplier[0] ? mcand : '0);
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        busy = 1'b0;
        case (state)
            IDLE: if (ev[2]) begin
`ifdef ALU_CONSOLE_MUL_EN
                next = (op_e'(SW[WIDTH+2:WIDTH]) == OP_MUL) ? MUL : EXEC;
`else
                next = EXEC;
`endif
            end
            EXEC: begin
                busy = 1'b1;
                next = DONE;
            end
            MUL: begin
                busy = 1'b1;
`ifdef ALU_CONSOLE_MUL_EN
                if (mul_cnt == SH_W'(WIDTH - 1)) next = DONE;
`else
                next = IDLE;
`endif
            end
            DONE: next = IDLE;
            default: next = IDLE;
        endcase
    end

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] r;
    logic [RES_W-1:0] exec_res;
    logic             exec_ovf, exec_err, lt;

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        lt       = unsig_r ? (a < b) : ($signed(a) < $signed(b));
        r        = '0;
        exec_ovf = 1'b0;
        exec_err = 1'b0;
        case (op_r)
            OP_ADD: begin
                r        = sum[WIDTH-1:0];
                exec_ovf = unsig_r ? sum[WIDTH]
                         : (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                r        = diff[WIDTH-1:0];
                exec_ovf = unsig_r ? diff[WIDTH]
                         : (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SLT: r = {{(WIDTH-1){1'b0}}, lt};
            OP_SHL: r = a << b[SH_W-1:0];
            default: exec_err = 1'b1;  // multiply reaching EXEC means it is not built in
        endcase
        exec_res = unsig_r ? {{WIDTH{1'b0}}, r} : {{WIDTH{r[WIDTH-1]}}, r};
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            a       <= '0;
            b       <= '0;
            result  <= '0;
            op_r    <= OP_ADD;
            unsig_r <= 1'b0;
            ovf     <= 1'b0;
            valid   <= 1'b0;
            err     <= 1'b0;
`ifdef ALU_CONSOLE_MUL_EN
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            mul_cnt <= '0;
            neg     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ev[0]) a <= operand;
                    if (ev[1]) b <= operand;
                    if (ev[2]) begin
                        op_r    <= op_e'(SW[WIDTH+2:WIDTH]);
                        unsig_r <= SW[WIDTH+3];
                        valid   <= 1'b0;
                        ovf     <= 1'b0;
                        err     <= 1'b0;
`ifdef ALU_CONSOLE_MUL_EN
                        mcand   <= {{WIDTH{1'b0}}, a_mag};
                        mplier  <= b_mag;
                        acc     <= '0;
                        mul_cnt <= '0;
                        neg     <= !SW[WIDTH+3] && (a_nx[WIDTH-1] ^ b_nx[WIDTH-1]);
`endif
                    end
                end
                EXEC: begin
                    result <= exec_res;
                    ovf    <= exec_ovf;
                    err    <= exec_err;
                    valid  <= 1'b1;
                end
`ifdef ALU_CONSOLE_MUL_EN
                MUL: begin
                    acc     <= acc_nx;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    mul_cnt <= mul_cnt + 1'b1;
                    if (mul_cnt == SH_W'(WIDTH - 1)) begin
                        result <= neg ? -acc_nx : acc_nx;
                        valid  <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign LEDR = {err, valid, busy, ovf};

    for (genvar d = 0; d < NDIG; d++) begin : g_hex
        hex_seg_decoder u_dec (
            .nib (result[4*d +: 4]),
            .seg (HEX[7*d +: 7])
        );
    end

endmodule

// File: tb/tb_alu_console.sv
// Self-checking bench for alu_console: directed cases plus random ops against an arithmetic model.
module tb_alu_console;

    localparam int W    = 8;
    localparam int D    = 16;
    localparam int NDIG = W / 2;
    localparam int RW   = 2 * W;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic                CLOCK_50 = 1'b0;
    logic                reset;
    logic [W+3:0]        SW;
    logic [2:0]          KEY;
    logic [3:0]          LEDR;
    logic [7*NDIG-1:0]   HEX;

    int n_checks = 0;
    int n_pass   = 0;

    alu_console #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .SW       (SW),
        .KEY      (KEY),
        .LEDR     (LEDR),
        .HEX      (HEX)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [7*NDIG-1:0] hex_of(input logic [RW-1:0] res);
        logic [7*NDIG-1:0] h;
        for (int i = 0; i < NDIG; i++) h[7*i +: 7] = GLYPH[res[4*i +: 4]];
        return h;
    endfunction

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] op, input logic u,
                                  output logic [RW-1:0] res, output logic ovf, output logic err);
        longint m, ua, ub, sa, sb, r, full;
        m  = longint'(1) << W;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - m : ua;
        sb = b[W-1] ? ub - m : ub;
        r = 0; ovf = 1'b0; err = 1'b0; full = 0;
        case (op)
            3'd0: begin
                r   = (ua + ub) % m;
                ovf = u ? (ua + ub >= m) : (sa + sb >= m / 2 || sa + sb < -m / 2);
            end
            3'd1: begin
                r   = (ua - ub + m) % m;
                ovf = u ? (ua < ub) : (sa - sb >= m / 2 || sa - sb < -m / 2);
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = u ? longint'(ua < ub) : longint'(sa < sb);
            3'd6: r = (ua << (ub % W)) % m;
            default: begin
`ifdef ALU_CONSOLE_MUL_EN
                full = u ? ua * ub : sa * sb;
                res  = full[RW-1:0];
                return;
`else
                err = 1'b1;
`endif
            end
        endcase
        res = RW'(r);
        if (!u && r >= m / 2) res = RW'(r + (longint'(1) << RW) - m);
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic press(input logic [2:0] mask, input logic [W-1:0] v);
        SW[W-1:0] = v;
        KEY = ~mask;
        repeat (D + 6) tick();
        KEY = 3'b111;
        repeat (4) tick();
    endtask

    // Holds execute long enough for the longest op; reports busy length and valid lag.
    task automatic do_exec(input logic [2:0] op, input logic u, output int busy_n, output int lag);
        int last_busy, first_valid;
        busy_n = 0; last_busy = -1; first_valid = -1;
        SW[W+2:W] = op;
        SW[W+3]   = u;
        KEY[2]    = 1'b0;
        for (int c = 0; c < D + W + 12; c++) begin
            @(negedge CLOCK_50);
            if (LEDR[1]) begin
                busy_n++;
                last_busy = c;
            end else if (LEDR[2] && busy_n > 0 && first_valid < 0) begin
                first_valid = c;
            end
        end
        @(posedge CLOCK_50);
        #1 KEY[2] = 1'b1;
        repeat (4) tick();
        lag = (first_valid < 0 || last_busy < 0) ? -1 : first_valid - last_busy;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                          input logic u, output int busy_n, output int lag);
        press(3'b001, a);
        press(3'b010, b);
        do_exec(op, u, busy_n, lag);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        KEY   = 3'b111;
        SW    = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (LEDR !== 4'b0000) $display("FAIL reset_ledr: got %b want 0000", LEDR);
        else n_pass++;
        n_checks++;
        if (HEX !== {NDIG{7'h40}}) $display("FAIL reset_hex: got %h want %h", HEX, {NDIG{7'h40}});
        else n_pass++;
    endtask

    task automatic test_directed();
        int bn, lag;
        run_op(8'h7F, 8'h01, 3'd0, 1'b0, bn, lag);
        n_checks++;
        if ({HEX, LEDR} !== {hex_of(16'hFF80), 4'b0101})
            $display("FAIL add_signed_ovf: got hex=%h ledr=%b want hex=%h ledr=0101", HEX, LEDR, hex_of(16'hFF80));
        else n_pass++;
        n_checks++;
        if (bn !== 1 || lag !== 1) $display("FAIL exec_timing: got busy=%0d lag=%0d want busy=1 lag=1", bn, lag);
        else n_pass++;

        run_op(8'hFF, 8'h01, 3'd0, 1'b1, bn, lag);
        n_checks++;
        if ({HEX, LEDR} !== {{NDIG{7'h40}}, 4'b0101})
            $display("FAIL add_unsigned_carry: got hex=%h ledr=%b want hex=%h ledr=0101", HEX, LEDR, {NDIG{7'h40}});
        else n_pass++;

        // Both keys together load the same value into A and B.
        press(3'b011, 8'h3C);
        do_exec(3'd0, 1'b1, bn, lag);
        n_checks++;
        if ({HEX, LEDR} !== {hex_of(16'h0078), 4'b0100})
            $display("FAIL dual_load: got hex=%h ledr=%b want hex=%h ledr=0100", HEX, LEDR, hex_of(16'h0078));
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0]  a, b;
        logic [2:0]    op;
        logic          u, ovf, err;
        logic [RW-1:0] res;
        int            bn, lag, exp_bn;
        for (int i = 0; i < 16; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            op = 3'($urandom_range(0, 7));
            u  = 1'($urandom);
            model(a, b, op, u, res, ovf, err);
`ifdef ALU_CONSOLE_MUL_EN
            exp_bn = (op == 3'd7) ? W : 1;
`else
            exp_bn = 1;
`endif
            run_op(a, b, op, u, bn, lag);
            n_checks++;
            if ({HEX, LEDR} !== {hex_of(res), err, 1'b1, 1'b0, ovf})
                $display("FAIL rand_op%0d a=%h b=%h op=%0d u=%b: got hex=%h ledr=%b want hex=%h ledr=%b",
                         i, a, b, op, u, HEX, LEDR, hex_of(res), {err, 1'b1, 1'b0, ovf});
            else n_pass++;
            n_checks++;
            if (bn !== exp_bn || lag !== 1)
                $display("FAIL rand_timing%0d op=%0d: got busy=%0d lag=%0d want busy=%0d lag=1", i, op, bn, lag, exp_bn);
            else n_pass++;
        end
    endtask

    task automatic test_op7();
        int bn, lag;
`ifdef ALU_CONSOLE_MUL_EN
        run_op(8'hFF, 8'hFF, 3'd7, 1'b1, bn, lag);
        n_checks++;
        if ({HEX, LEDR} !== {hex_of(16'hFE01), 4'b0100} || bn !== W)
            $display("FAIL mul_unsigned: got hex=%h ledr=%b busy=%0d want hex=%h ledr=0100 busy=%0d",
                     HEX, LEDR, bn, hex_of(16'hFE01), W);
        else n_pass++;
        do_exec(3'd7, 1'b0, bn, lag);
        n_checks++;
        if ({HEX, LEDR} !== {hex_of(16'h0001), 4'b0100})
            $display("FAIL mul_signed: got hex=%h ledr=%b want hex=%h ledr=0100", HEX, LEDR, hex_of(16'h0001));
        else n_pass++;
`else
        run_op(8'h12, 8'h34, 3'd7, 1'b1, bn, lag);
        n_checks++;
        if ({HEX, LEDR} !== {{NDIG{7'h40}}, 4'b1100} || bn !== 1)
            $display("FAIL op7_error: got hex=%h ledr=%b busy=%0d want hex=%h ledr=1100 busy=1",
                     HEX, LEDR, bn, {NDIG{7'h40}});
        else n_pass++;
        do_exec(3'd0, 1'b1, bn, lag);
        n_checks++;
        if ({HEX, LEDR} !== {hex_of(16'h0046), 4'b0100})
            $display("FAIL op7_error_clear: got hex=%h ledr=%b want hex=%h ledr=0100", HEX, LEDR, hex_of(16'h0046));
        else n_pass++;
`endif
    endtask

    // Bounce, then a stable low; SW changes one cycle before and one cycle after
    // the expected acceptance edge pin down exactly when (and how often) A loads.
    task automatic test_debounce();
        int bn, lag;
        press(3'b010, 8'h00);
        for (int i = 0; i < 5; i++) begin
            KEY[0] = 1'b0;
            repeat (3) tick();
            KEY[0] = 1'b1;
            repeat (3) tick();
        end
        SW[W-1:0] = 8'hA5;
        KEY[0]    = 1'b0;
        repeat (D + 1) tick();
        SW[W-1:0] = 8'h5C;
        tick();
        SW[W-1:0] = 8'h33;
        repeat (8) tick();
        KEY[0] = 1'b1;
        repeat (4) tick();
        do_exec(3'd0, 1'b1, bn, lag);
        n_checks++;
        if ({HEX, LEDR} !== {hex_of(16'h005C), 4'b0100})
            $display("FAIL debounce_single_load: got hex=%h ledr=%b want hex=%h ledr=0100", HEX, LEDR, hex_of(16'h005C));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bn, lag;
        logic hit;
        hit = 1'b0;
`ifdef ALU_CONSOLE_MUL_EN
        press(3'b011, 8'hFF);
        SW[W+2:W] = 3'd7;
        SW[W+3]   = 1'b1;
        KEY[2]    = 1'b0;
        bn = 0;
        for (int c = 0; c < D + W + 12 && !hit; c++) begin
            @(negedge CLOCK_50);
            if (LEDR[1]) bn++;
            if (bn == 4) begin
                reset = 1'b1;
                KEY   = 3'b111;
                hit   = 1'b1;
            end
        end
`else
        run_op(8'h9A, 8'h11, 3'd4, 1'b1, bn, lag);
        @(negedge CLOCK_50);
        reset = 1'b1;
        hit   = 1'b1;
`endif
        if (!hit) reset = 1'b1;
        n_checks++;
        if (!hit) $display("FAIL reset_mid_reach: got busy cycles=%0d want 4 before timeout", bn);
        else n_pass++;
        KEY = 3'b111;
        @(posedge CLOCK_50);
        #1;
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({HEX, LEDR} !== {{NDIG{7'h40}}, 4'b0000})
            $display("FAIL reset_mid_clear: got hex=%h ledr=%b want hex=%h ledr=0000", HEX, LEDR, {NDIG{7'h40}});
        else n_pass++;
        run_op(8'h12, 8'h34, 3'd0, 1'b1, bn, lag);
        n_checks++;
        if ({HEX, LEDR} !== {hex_of(16'h0046), 4'b0100} || bn !== 1)
            $display("FAIL reset_mid_recover: got hex=%h ledr=%b busy=%0d want hex=%h ledr=0100 busy=1",
                     HEX, LEDR, bn, hex_of(16'h0046));
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        KEY   = 3'b111;
        SW    = '0;
        test_reset();
        test_directed();
        test_op7();
        test_debounce();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
